// File: rtl/cm_pkg.sv
// Shared types and constants for the two-input merge element.
package cm_pkg;

    // Input-side handshake states
    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    // Output-side handshake states
    typedef enum logic [1:0] {
        OUT_IDLE = 2'b00,
        OUT_SEND = 2'b01,
        OUT_RTZ  = 2'b10
    } out_state_t;

    // Channel identifiers, also used as the source tag on Sel_out
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: a lone request wins outright; on a tie the
// channel that did not win last time is granted. Purely combinational so that
// wider merge trees can register the result wherever suits them.
module rr_arb2
    import cm_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // One-hot grant selection, forced to zero when arbitration is disabled
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (last_grant == CH_A) begin
                        gnt = 2'b10;
                    end else begin
                        gnt = 2'b01;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/cm_merge.sv
// Two-input merge element: collects 4-phase Send/Ack tokens from channels a
// and b into a one-entry buffer and re-issues them on a single output stream
// with a tag naming the source channel. Input and output handshakes run as
// independent FSMs that communicate only through the buffer's full flag.
module cm_merge
    import cm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         MR_n,
    input  logic         Send_in_a,
    input  logic [W-1:0] Data_in_a,
    output logic         Ack_out_a,
    input  logic         Send_in_b,
    input  logic [W-1:0] Data_in_b,
    output logic         Ack_out_b,
    output logic         Send_out,
    output logic [W-1:0] Data_out,
    output logic         Sel_out,
    input  logic         Ack_in,
    output logic         CP
);

    in_state_t    in_state_r;
    in_state_t    in_next_s;
    out_state_t   out_state_r;
    out_state_t   out_next_s;

    logic         full_r;
    logic [W-1:0] buf_r;
    logic         tag_r;
    logic         owner_r;
    logic         last_grant_r;
    logic         ack_a_r;
    logic         ack_b_r;
    logic         send_out_r;
    logic         cp_r;

    logic [1:0]   gnt_s;
    logic         arb_en_s;
    logic         accept_s;
    logic         grant_ch_s;
    logic [W-1:0] grant_data_s;
    logic         owner_send_s;
    logic         release_s;
    logic         drain_s;

    // Arbitrate only when idle with room in the buffer
    assign arb_en_s     = (in_state_r == IN_IDLE) && !full_r;
    assign accept_s     = |gnt_s;
    assign grant_ch_s   = gnt_s[1] ? CH_B : CH_A;
    assign grant_data_s = gnt_s[1] ? Data_in_b : Data_in_a;
    assign owner_send_s = (owner_r == CH_B) ? Send_in_b : Send_in_a;

    rr_arb2 u_arb (
        .req        ({Send_in_b, Send_in_a}),
        .last_grant (last_grant_r),
        .en         (arb_en_s),
        .gnt        (gnt_s)
    );

    // Input FSM next state: capture on grant, then wait for the owner to return to zero
    always_comb begin
        in_next_s = in_state_r;
        release_s = 1'b0;
        case (in_state_r)
            IN_IDLE: begin
                if (accept_s) begin
                    in_next_s = IN_ACK;
                end else begin
                    in_next_s = IN_IDLE;
                end
            end
            IN_ACK: begin
                if (!owner_send_s) begin
                    release_s = 1'b1;
                    in_next_s = IN_IDLE;
                end else begin
                    in_next_s = IN_ACK;
                end
            end
            default: in_next_s = IN_IDLE;
        endcase
    end

    // Output FSM next state: Send_out only rises once Ack_in is seen low
    always_comb begin
        out_next_s = out_state_r;
        drain_s    = 1'b0;
        case (out_state_r)
            OUT_IDLE: begin
                if (full_r && !Ack_in) begin
                    out_next_s = OUT_SEND;
                end else begin
                    out_next_s = OUT_IDLE;
                end
            end
            OUT_SEND: begin
                if (Ack_in) begin
                    drain_s    = 1'b1;
                    out_next_s = OUT_RTZ;
                end else begin
                    out_next_s = OUT_SEND;
                end
            end
            OUT_RTZ: begin
                if (!Ack_in) begin
                    out_next_s = OUT_IDLE;
                end else begin
                    out_next_s = OUT_RTZ;
                end
            end
            default: out_next_s = OUT_IDLE;
        endcase
    end

    // State registers for both FSMs
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            in_state_r  <= IN_IDLE;
            out_state_r <= OUT_IDLE;
        end else begin
            in_state_r  <= in_next_s;
            out_state_r <= out_next_s;
        end
    end

    // Token buffer: filled by the input side, emptied (and zeroed) by the output side
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            full_r <= 1'b0;
            buf_r  <= '0;
            tag_r  <= CH_A;
        end else if (accept_s) begin
            full_r <= 1'b1;
            buf_r  <= grant_data_s;
            tag_r  <= grant_ch_s;
        end else if (drain_s) begin
            full_r <= 1'b0;
            buf_r  <= '0;
            tag_r  <= CH_A;
        end else begin
            full_r <= full_r;
            buf_r  <= buf_r;
            tag_r  <= tag_r;
        end
    end

    // Arbitration history; last_grant resets to b so a wins the first tie
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            owner_r      <= CH_A;
            last_grant_r <= CH_B;
        end else if (accept_s) begin
            owner_r      <= grant_ch_s;
            last_grant_r <= grant_ch_s;
        end else begin
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Per-channel acknowledges: raised on capture, dropped when the owner releases
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
        end else if (accept_s) begin
            ack_a_r <= (grant_ch_s == CH_A);
            ack_b_r <= (grant_ch_s == CH_B);
        end else if (release_s) begin
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
        end else begin
            ack_a_r <= ack_a_r;
            ack_b_r <= ack_b_r;
        end
    end

    // Registered output request and one-cycle capture pulse
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            send_out_r <= 1'b0;
            cp_r       <= 1'b0;
        end else begin
            send_out_r <= (out_next_s == OUT_SEND);
            cp_r       <= accept_s;
        end
    end

    assign Ack_out_a = ack_a_r;
    assign Ack_out_b = ack_b_r;
    assign Send_out  = send_out_r;
    assign Data_out  = buf_r;
    assign Sel_out   = tag_r;
    assign CP        = cp_r;

endmodule
